ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset, 0xF3 set sample rate) to the mouse/keyboard on PS2_CLK/PS2_DAT.
- Complements the existing PS/2 receive path that produces keycode and mouse movement.
- Drives both lines open-drain through output enables. The top level ties each line low when its enable is 1 and leaves it high-Z otherwise.
- Sits beside the receiver. `busy` tells the receiver to ignore edges while a transmit is in progress.

---
 rtl/ps2_pkg.sv | 10 +
 rtl/ps2_host_tx_if.sv | 22 ++
 rtl/ps2_sync_edge.sv | 16 +
 rtl/ps2_host_tx.sv | 135 +++++++++++++
 tb/tb_ps2_host_tx.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 transmitter states, common command bytes and parity helper
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, BITS, ACK, WAIT_IDLE} ps2_tx_state_t;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake, status and open-drain PS/2 pin enables of the host transmitter
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic       nack;
  logic       timeout;
  modport master (
    output tx_valid, tx_data, ps2_clk_in, ps2_dat_in,
    input  tx_ready, ps2_clk_oe, ps2_dat_oe, busy, done, nack, timeout
  );
  modport slave (
    input  tx_valid, tx_data, ps2_clk_in, ps2_dat_in,
    output tx_ready, ps2_clk_oe, ps2_dat_oe, busy, done, nack, timeout
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizer with falling-edge detect for a raw PS/2 line
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic fe
);
  logic s1, s2, prev;
  // idle PS/2 lines float high, so start from 1 to avoid a false edge after reset
  always_ff @(posedge clk or posedge reset)
    if (reset) {s1, s2, prev} <= 3'b111;
    else {s1, s2, prev} <= {d, s1, s2};
  assign level = s2;
  assign fe    = prev & ~s2;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain clk/dat enables.
// Define PS2_HOST_TX_RETRY_EN to retry a NACKed or timed-out frame once before reporting.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000 * 15
) (
  input logic          clk,
  input logic          reset,
  ps2_host_tx_if.slave bus
);
  localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
  localparam logic [CW-1:0] INH_PRE  = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  ps2_tx_state_t state, state_n;
  logic [3:0]    bit_cnt, bit_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [10:0]   frame, frame_n;
  logic          clk_oe, clk_oe_n, dat_oe, dat_oe_n;
  logic          done, done_n, nack, nack_n, timeout, to_n, fin;
  logic          clk_lvl, clk_fe, dat_lvl;
  logic [1:0]    dat_s;
`ifdef PS2_HOST_TX_RETRY_EN
  logic          retry, retry_n;
`endif
  ps2_sync_edge clk_sync (.clk(clk), .reset(reset), .d(bus.ps2_clk_in), .level(clk_lvl), .fe(clk_fe));
  always_ff @(posedge clk or posedge reset)
    if (reset) dat_s <= 2'b11;
    else dat_s <= {dat_s[0], bus.ps2_dat_in};
  assign dat_lvl = dat_s[1];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      cnt     <= '0;
      frame   <= '1;
      {clk_oe, dat_oe, done, nack, timeout} <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_n;
      cnt     <= cnt_n;
      frame   <= frame_n;
      {clk_oe, dat_oe, done, nack, timeout} <= {clk_oe_n, dat_oe_n, done_n, nack_n, to_n};
    end
`ifdef PS2_HOST_TX_RETRY_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) retry <= 1'b0;
    else retry <= retry_n;
`endif
  // frame bit 0 is the start bit, put on the line while the clock is still inhibited
  always_comb begin
    state_n  = state;
    bit_n    = bit_cnt;
    frame_n  = frame;
    cnt_n    = clk_fe ? '0 : cnt + CW'(1);
    clk_oe_n = clk_oe;
    dat_oe_n = dat_oe;
    nack_n   = nack;
    to_n     = timeout;
    done_n   = 1'b0;
    fin      = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_n  = retry;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.tx_valid) begin
          frame_n  = {1'b1, odd_parity(bus.tx_data), bus.tx_data, 1'b0};
          bit_n    = '0;
          nack_n   = 1'b0;
          to_n     = 1'b0;
          clk_oe_n = 1'b1;
          dat_oe_n = 1'b0;
          state_n  = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          retry_n  = 1'b0;
`endif
        end
      end
      INHIBIT: begin
        cnt_n = cnt + CW'(1);
        if (cnt == INH_PRE) dat_oe_n = 1'b1;
        if (cnt == INH_LAST) begin
          clk_oe_n = 1'b0;
          cnt_n    = '0;
          bit_n    = '0;
          state_n  = BITS;
        end
      end
      BITS:
        if (clk_fe) begin
          dat_oe_n = ~frame[bit_cnt + 4'd1];
          bit_n    = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) state_n = ACK;
        end else if (cnt == TO_LAST) {fin, to_n} = 2'b11;
      ACK:
        if (clk_fe) begin
          nack_n  = dat_lvl;
          state_n = WAIT_IDLE;
        end else if (cnt == TO_LAST) {fin, to_n} = 2'b11;
      WAIT_IDLE:
        if (clk_lvl && dat_lvl) fin = 1'b1;
        else if (cnt == TO_LAST) {fin, to_n} = 2'b11;
      default: state_n = IDLE;
    endcase
    if (fin) begin
      state_n  = IDLE;
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      done_n   = 1'b1;
      cnt_n    = '0;
`ifdef PS2_HOST_TX_RETRY_EN
      if ((nack_n || to_n) && !retry) begin
        state_n  = INHIBIT;
        clk_oe_n = 1'b1;
        done_n   = 1'b0;
        nack_n   = 1'b0;
        to_n     = 1'b0;
        retry_n  = 1'b1;
      end
`endif
    end
  end
  assign bus.tx_ready   = state == IDLE;
  assign bus.busy       = state != IDLE;
  assign bus.ps2_clk_oe = clk_oe;
  assign bus.ps2_dat_oe = dat_oe;
  assign bus.done       = done;
  assign bus.nack       = nack;
  assign bus.timeout    = timeout;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench for ps2_host_tx with an open-drain PS/2 device model
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int INH = 100;
  localparam int TO  = 3000;
  localparam int H   = 20;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, dev_clk = 1'b1, dev_dat = 1'b1;
  int   errors = 0, checks = 0, frames = 0, done_cnt = 0, inh_run = 0, start_at = 0;
  logic prev_clk_oe = 1'b0, prev_dat_oe = 1'b0;
  logic done_nack = 1'b0, done_to = 1'b0, done_oe = 1'b0, done_rdy = 1'b0;
  time  done_t = 0, last_fe_t = 0;
  ps2_host_tx_if bus();
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.ps2_clk_in = ~bus.ps2_clk_oe & dev_clk;
  assign bus.ps2_dat_in = ~bus.ps2_dat_oe & dev_dat;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end
  always @(negedge clk) begin
    if (bus.ps2_clk_oe) begin
      if (!prev_clk_oe) begin
        frames++;
        inh_run  = 0;
        start_at = 0;
      end
      inh_run++;
      if (bus.ps2_dat_oe && !prev_dat_oe) start_at = inh_run;
    end
    prev_clk_oe = bus.ps2_clk_oe;
    prev_dat_oe = bus.ps2_dat_oe;
    if (bus.done) begin
      done_cnt++;
      done_nack = bus.nack;
      done_to   = bus.timeout;
      done_oe   = bus.ps2_clk_oe | bus.ps2_dat_oe;
      done_rdy  = bus.tx_ready;
      done_t    = $time;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // line levels a device should see: start, data LSB first, odd parity, stop
  function automatic logic [10:0] line_bits(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask
  task automatic dev_frame(input int np, input bit ackb, output logic [10:0] got, output bit ok);
    int t;
    got = '1;
    last_fe_t = 0;
    t = 0;
    while (!bus.ps2_clk_oe && t < TO + INH + 1000) begin @(negedge clk); t++; end
    while (bus.ps2_clk_oe && t < TO + INH + 1000) begin @(negedge clk); t++; end
    ok = !bus.ps2_clk_oe;
    got[0] = ~bus.ps2_dat_oe & dev_dat;
    repeat (5) @(negedge clk);
    for (int i = 1; i <= np; i++) begin
      dev_clk = 1'b0;
      last_fe_t = $time;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      got[i] = ~bus.ps2_dat_oe & dev_dat;
      repeat (H) @(negedge clk);
    end
    if (np == 10) begin
      dev_dat = ackb;
      repeat (H) @(negedge clk);
      dev_clk = 1'b0;
      last_fe_t = $time;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (2) @(negedge clk);
      dev_dat = 1'b1;
    end
  endtask
  task automatic transfer(input string tag, input logic [7:0] b, input int np1, input bit ack1,
                          input int np2, input bit ack2, input bit poke);
    logic [10:0] got, mask;
    bit ok, ackf;
    int d0, f0, np, att, lat;
    d0 = done_cnt;
    f0 = frames;
    send(b);
    if (poke) begin
      fork
        dev_frame(np1, ack1, got, ok);
        begin
          repeat (200) @(negedge clk);
          check({tag, "_busy"}, 32'(bus.busy), 1);
          bus.tx_valid = 1'b1;
          bus.tx_data  = ~b;
          @(negedge clk);
          bus.tx_valid = 1'b0;
        end
      join
    end else dev_frame(np1, ack1, got, ok);
    np = np1;
    ackf = ack1;
    att = 1;
    if (RETRY && (ack1 || np1 < 10)) begin
      dev_frame(np2, ack2, got, ok);
      np = np2;
      ackf = ack2;
      att = 2;
    end
    check({tag, "_inhibit_end"}, 32'(ok), 1);
    mask = 11'((1 << (np + 1)) - 1);
    check({tag, "_bits"}, 32'(got & mask), 32'(line_bits(b) & mask));
    for (int i = 0; i < TO + 500 && done_cnt == d0; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_frames"}, frames - f0, att);
    check({tag, "_nack"}, 32'(done_nack), 32'(np == 10 && ackf));
    check({tag, "_timeout"}, 32'(done_to), 32'(np < 10));
    check({tag, "_oe_at_done"}, 32'(done_oe), 0);
    check({tag, "_ready_at_done"}, 32'(done_rdy), 1);
    check({tag, "_inhibit_len"}, inh_run, INH);
    check({tag, "_start_at"}, start_at, INH);
    if (np < 10 && last_fe_t != 0) begin
      lat = int'((done_t - last_fe_t) / 10);
      check({tag, "_to_latency_ok"}, 32'(lat >= TO && lat <= TO + 5), 1);
    end
  endtask
  initial begin
    logic [10:0] got;
    bit ok;
    int d0;
    logic [7:0] b;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.tx_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_nack", 32'(bus.nack), 0);
    check("rst_timeout", 32'(bus.timeout), 0);
    check("rst_oe", 32'({bus.ps2_clk_oe, bus.ps2_dat_oe}), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    transfer("enable", PS2_CMD_ENABLE, 10, 1'b0, 10, 1'b0, 1'b0);
    transfer("reset_cmd", PS2_CMD_RESET, 10, 1'b0, 10, 1'b0, 1'b0);
    transfer("set_rate_nack", PS2_CMD_SET_RATE, 10, 1'b1, 10, 1'b0, 1'b0);
    transfer("stall", 8'hA5, 5, 1'b0, 0, 1'b0, 1'b0);
    transfer("busy_ignore", 8'h3C, 10, 1'b0, 10, 1'b0, 1'b1);
    d0 = done_cnt;
    send(8'h5A);
    dev_frame(6, 1'b0, got, ok);
    check("abort_bits", 32'(got[6:0]), 32'(line_bits(8'h5A) & 11'h07F));
    check("abort_pre_dat_oe", 32'(bus.ps2_dat_oe), 1);
    #3 reset = 1'b1;
    #1;
    check("abort_oe", 32'({bus.ps2_clk_oe, bus.ps2_dat_oe}), 0);
    check("abort_busy", 32'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_ready", 32'(bus.tx_ready), 1);
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      transfer($sformatf("rand%0d", k), b, 10, $urandom_range(0, 3) == 0, 10, 1'b0, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
